// File: rtl/cam_frame_writer.sv
// cam_frame_writer
// Turns the OV-series YUV422 byte stream into linear frame-buffer writes.
// The luma byte of each pair is kept, cut down to its PIX_W most significant
// bits and written at row_base + col. All logic runs in the camera pclk domain.
//
// Optional build macro: CAM_GEOM_CHECK_EN
//   defined   -> err latches any line that does not end with exactly H_ACTIVE
//                luma bytes and any frame that does not end with V_ACTIVE lines.
//   undefined -> err is tied low and no checking logic exists.
module cam_frame_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int PIX_W    = 4,
    parameter int Y_FIRST  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cam_href,
    input  logic              cam_vsync,
    input  logic [7:0]        cam_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              wr_en,
    output logic              frame_done,
    output logic              busy,
    output logic              err
);

    // col counts one past H_ACTIVE so an overlong line stays distinguishable
    // from an exact one; row saturates at V_ACTIVE.
    localparam int COL_W = $clog2(H_ACTIVE + 2);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);

    localparam logic [COL_W-1:0]  COL_FULL  = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0]  COL_SAT   = COL_W'(H_ACTIVE + 1);
    localparam logic [ROW_W-1:0]  ROW_FULL  = ROW_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

    // Byte phase that carries luma: phase 0 when luma leads the pair.
    localparam logic LUMA_PHASE = (Y_FIRST != 0) ? 1'b0 : 1'b1;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_SYNC       = 2'd1;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd2;
    localparam logic [1:0] ST_ACTIVE     = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              href_q;
    logic              vsync_q;
    logic              phase_q, phase_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;

    logic href_rise;
    logic href_fall;
    logic vsync_rise;
    logic vsync_fall;
    logic cur_phase;
    logic is_luma;

    // Only the upper PIX_W bits of the camera byte are stored.
    logic unused_cam_bits;
    assign unused_cam_bits = ^cam_data;

    // Edge detection against a single registered copy of the sync lines.
    assign href_rise  =  cam_href  & ~href_q;
    assign href_fall  = ~cam_href  &  href_q;
    assign vsync_rise =  cam_vsync & ~vsync_q;
    assign vsync_fall = ~cam_vsync &  vsync_q;

    // A rising href restarts the pair, so the first byte of a line is phase 0
    // even though phase_q has not been cleared yet.
    assign cur_phase = href_rise ? 1'b0 : phase_q;
    assign is_luma   = cam_href && (cur_phase == LUMA_PHASE);

    // Registered copies of href/vsync for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            href_q  <= cam_href;
            vsync_q <= cam_vsync;
        end
    end

    // Next-state logic: frame sequencing, pixel counting and write generation.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        col_d        = col_q;
        row_d        = row_q;
        row_base_d   = row_base_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        frame_done_d = 1'b0;

        if (!enable) begin
            // Losing configuration abandons the frame silently.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SYNC;
                end

                ST_SYNC: begin
                    // Seeing vsync high guarantees we start on a frame edge.
                    if (cam_vsync) begin
                        state_d = ST_WAIT_FRAME;
                    end
                end

                ST_WAIT_FRAME: begin
                    if (vsync_fall) begin
                        col_d      = '0;
                        row_d      = '0;
                        row_base_d = '0;
                        phase_d    = 1'b0;
                        state_d    = ST_ACTIVE;
                    end
                end

                ST_ACTIVE: begin
                    if (vsync_rise) begin
                        // Frame over; a line still in flight is dropped
                        // without counting it.
                        frame_done_d = 1'b1;
                        state_d      = ST_WAIT_FRAME;
                    end else begin
                        if (cam_href) begin
                            phase_d = ~cur_phase;
                        end

                        if (is_luma) begin
                            if ((col_q < COL_FULL) && (row_q < ROW_FULL)) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = row_base_q + ADDR_W'(col_q);
                                wr_data_d = cam_data[7 -: PIX_W];
                            end
                            if (col_q != COL_SAT) begin
                                col_d = col_q + COL_W'(1);
                            end
                        end

                        if (href_fall) begin
                            if (row_q < ROW_FULL) begin
                                row_d = row_q + ROW_W'(1);
                            end
                            row_base_d = row_base_q + LINE_STEP;
                            col_d      = '0;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_ACTIVE);
    end

    // State and output registers, all cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            row_base_q   <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_base_q   <= row_base_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

`ifdef CAM_GEOM_CHECK_EN
    logic err_q, err_d;

    // Sticky geometry error: wrong luma count per line or wrong line count per frame.
    always_comb begin
        err_d = err_q;
        if (enable && (state_q == ST_ACTIVE)) begin
            if (vsync_rise) begin
                if (row_q != ROW_FULL) begin
                    err_d = 1'b1;
                end
            end else if (href_fall && (col_q != COL_FULL)) begin
                err_d = 1'b1;
            end
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/cam_frame_writer.md
# cam_frame_writer

Converts the OV-series camera byte stream (YUV422, two bytes per pixel) into frame-buffer write transactions. It keeps the luma byte, truncates it to `PIX_W` bits, and generates a linear 640×480 write address, write enable and frame-boundary status. It sits between the camera pins and port A of the dual-port frame BRAM, in the camera `pclk` domain, and is gated by the SCCB configuration-done flag.

## Interface
Parameters:
- `H_ACTIVE`, 640: pixels per line written.
- `V_ACTIVE`, 480: lines per frame written.
- `ADDR_W`, 19: width of the write address; must satisfy 2^ADDR_W ≥ H_ACTIVE·V_ACTIVE.
- `PIX_W`, 4: stored bits per pixel; these are the MSBs of the luma byte.
- `Y_FIRST`, 1: 1 means the luma byte is the first byte of each pair; 0 means it is the second.

Ports:
- `clk`, in, 1: camera pixel clock (`pclk`). This is the only clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: configuration done; capture is allowed while high.
- `cam_href`, in, 1: line valid, synchronous to `clk`.
- `cam_vsync`, in, 1: frame sync, active-high during vertical blanking.
- `cam_data`, in, 8: camera byte.
- `wr_addr`, out, ADDR_W: BRAM write address.
- `wr_data`, out, PIX_W: BRAM write data.
- `wr_en`, out, 1: BRAM write strobe; one pixel per high cycle.
- `frame_done`, out, 1: single-cycle pulse at the end of each captured frame.
- `busy`, out, 1: high while a frame is being captured.
- `err`, out, 1: sticky geometry-error flag (see Configuration).

## Operation
- State machine: IDLE → SYNC → WAIT_FRAME → ACTIVE → back to WAIT_FRAME.
- IDLE: nothing is written. When `enable` = 1, go to SYNC.
- SYNC: wait for `cam_vsync` = 1, which guarantees that capture starts on a frame boundary. Then go to WAIT_FRAME.
- WAIT_FRAME: wait for the falling edge of `cam_vsync`. On that edge, clear `col`, `row`, `row_base` and the byte phase, then go to ACTIVE. `busy` = 1 while in ACTIVE.
- ACTIVE, byte handling:
  - The byte phase clears on every rising edge of `cam_href` and toggles on every cycle with `cam_href` = 1.
  - The luma byte is the byte in phase 0 when `Y_FIRST` = 1, otherwise the byte in phase 1.
- ACTIVE, luma byte with `col` < H_ACTIVE and `row` < V_ACTIVE:
  - Register `wr_addr` = `row_base` + `col`.
  - Register `wr_data` = `cam_data[7:8-PIX_W]`.
  - Assert `wr_en`.
  - Increment `col`.
- Luma bytes with `col` ≥ H_ACTIVE, or arriving while `row` ≥ V_ACTIVE, are dropped: no write, and `col` saturates.
- Falling edge of `cam_href`:
  - `row` += 1 (saturating at V_ACTIVE).
  - `row_base` += H_ACTIVE.
  - `col` ← 0.
- Addresses are generated without a multiplier; `row_base` is an ADDR_W-wide accumulator.
- Rising edge of `cam_vsync` in ACTIVE:
  - Pulse `frame_done` for one cycle.
  - Clear `busy`.
  - Go to WAIT_FRAME.
  - If `cam_href` is still high (truncated line), abort the line without incrementing `row`.
- `enable` falling in any state:
  - Go to IDLE on the next cycle.
  - `wr_en` and `busy` go low on the next cycle.
  - No `frame_done` is issued.
- Reset in mid-frame: all state clears immediately. After reset is released, the block goes through IDLE and SYNC again before capturing.
- Edge detection uses one registered copy of `cam_href` and `cam_vsync`.

## Timing
- Reset values: `wr_addr` = 0, `wr_data` = 0, `wr_en` = 0, `frame_done` = 0, `busy` = 0, `err` = 0. State is IDLE.
- Latency: a luma byte sampled at edge N produces `wr_en`/`wr_addr`/`wr_data` valid after edge N+1. `wr_en` is high for exactly one cycle per pixel.
- The maximum write rate is one write every 2 cycles.
- `frame_done` is asserted in the cycle after the `cam_vsync` rising edge is sampled.
- The transition to ACTIVE happens in the cycle after the `cam_vsync` falling edge is sampled. The first pixel of the frame goes to address 0.
- A `cam_href` rising edge and a luma byte in the same cycle form a valid phase-0 byte.

## Configuration
- `CAM_GEOM_CHECK_EN` defined:
  - `err` is set if a line ends (falling edge of `cam_href`) with `col` ≠ H_ACTIVE.
  - `err` is set if a frame ends with `row` ≠ V_ACTIVE.
  - Once set, `err` stays set until `reset`.
- `CAM_GEOM_CHECK_EN` undefined: `err` is tied to 0 and no checking logic is synthesized. Write behaviour is identical in both builds.

## Test plan
- Reset, then `enable` = 1, one vsync pulse, then 480 lines of 1280 bytes with Y = 0xA0 and UV = 0x55 → 307200 writes; `wr_data` = 0xA on every write; addresses 0…307199 in order; one `frame_done` pulse; `err` = 0.
- `enable` = 1 in the middle of a frame (`cam_vsync` low) → no writes until the next vsync high→low sequence; the first write is at address 0.
- A line of 1300 bytes (650 pixels) in line 3 → only 640 writes for that line, ending at address 2559; the next line starts at 2560; `err` = 1 (with the macro) or 0 (without).
- `Y_FIRST` = 0 with byte pairs {0x10, 0xF0} → every `wr_data` = 0xF.
- `enable` dropped at line 100, column 37 → `wr_en` = 0 and `busy` = 0 one cycle later; no `frame_done`.
- `reset` asserted in the middle of a line → all outputs 0 in the same cycle; after release, capture resumes only after a full vsync pulse.
